rtc_poll_sched: RTL and testbench
=================================

// Module: rtc_poll_sched
// PURPOSE
//  Periodic read scheduler for the DS1302 front end. On every poll interval it
//  sequences three single-byte reads through the read engine: seconds (81h),
//  minutes (83h) and hours (85h). It then commits all three BCD bytes together,
//  so the FND/display controllers always see one coherent time snapshot.
//  Sits between the tick generator and the ds1302 read engine.
// PARAMETERS
//  POLL_TICKS   100     tick pulses between poll starts (>=1)
//  TIMEOUT_CYC  1000    clk cycles allowed in WAIT before abort (RTC_SCHED_TIMEOUT_EN only)
//  CMD_SEC      8'h81   read command, seconds register
//  CMD_MIN      8'h83   read command, minutes register
//  CMD_HOUR     8'h85   read command, hours register
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  tick        in   1  1-cycle enable pulse (scan/poll timebase)
//  force_poll  in   1  1-cycle request for an immediate poll
//  rd_start    out  1  1-cycle start strobe to the read engine
//  rd_cmd      out  8  command byte; valid while rd_start=1, held until next ISSUE
//  rd_busy     in   1  read engine busy
//  rd_done     in   1  1-cycle: rd_data valid
//  rd_data     in   8  byte returned by the read engine
//  sec_bcd     out  8  committed seconds, {tens,units}; CH bit masked
//  min_bcd     out  8  committed minutes, {tens,units}
//  hour_bcd    out  8  committed hours, bits[5:0] only, [7:6]=0
//  time_valid  out  1  1-cycle pulse on commit
//  err         out  1  sticky timeout flag
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, idx=0, poll_cnt=0, pend=0, rd_start=0,
//    rd_cmd=0, sec/min/hour_bcd=0, time_valid=0, err=0, staging regs=0.
//  poll_cnt: increments on tick in every state. When tick and poll_cnt==POLL_TICKS-1,
//    it wraps to 0 and sets pend. force_poll also sets pend. pend is 1-deep; extra
//    requests while pend=1 are merged.
//  FSM:
//   IDLE   : if pend -> clear pend, idx=0, go ISSUE.
//   ISSUE  : if rd_busy=0, assert rd_start for exactly 1 cycle with rd_cmd=CMD[idx],
//            then go WAIT. If rd_busy=1, hold in ISSUE with no strobe.
//   WAIT   : on rd_done, capture rd_data into stage[idx].
//            If idx<2: idx++ and go ISSUE. If idx==2: go COMMIT.
//            rd_done seen in any other state is ignored.
//   COMMIT : 1 cycle. Copy all three stages to the outputs in the same cycle,
//            pulse time_valid=1, clear err, go IDLE.
//  Capture masking:
//   - sec_bcd  = {1'b0, rd_data[6:0]}  (CH bit dropped)
//   - min_bcd  = {1'b0, rd_data[6:0]}
//   - hour_bcd = {2'b00, rd_data[5:0]}
//   - No BCD range check; the data is passed through.
//  Latency: rd_start is issued 1 clk after IDLE sees pend (rd_busy=0).
//    time_valid is issued 1 clk after the third rd_done.
//  Output stability: sec/min/hour_bcd change only in COMMIT. A partial sequence
//    never reaches the outputs.
//  A request raised mid-sequence sets pend; the next sequence starts on return to IDLE.
//  rst mid-sequence: everything is returned to reset values. rd_start is deasserted
//    in the same cycle, and any in-flight engine transfer is ignored.
// CONFIGURATION
//  RTC_SCHED_TIMEOUT_EN defined:
//   - wait_cnt is cleared on entry to WAIT and counts clk while in WAIT.
//   - When wait_cnt==TIMEOUT_CYC-1 with no rd_done: abort, set err=1, go IDLE.
//   - On abort, outputs keep the last committed values and time_valid stays 0.
//   - err stays 1 until the next successful COMMIT or reset.
//  RTC_SCHED_TIMEOUT_EN undefined:
//   - No counter; WAIT holds indefinitely for rd_done.
//   - err is tied to 0.
// TESTING
//  1 POLL_TICKS=4, tick every 10 clk, engine returns 8'h59/8'h30/8'h12 ->
//    rd_cmd sequence 81h,83h,85h; then time_valid=1 with sec=59, min=30, hour=12.
//  2 Seconds returns 8'hD9 and hours returns 8'hD2 -> sec_bcd=8'h59, hour_bcd=8'h12.
//  3 force_poll while in WAIT for idx=1 -> sequence completes, then a new sequence
//    starts at 81h. Two force_poll pulses give only one extra sequence.
//  4 rd_busy=1 for 20 clk during ISSUE -> no rd_start until rd_busy falls; rd_start
//    width is exactly 1 clk.
//  5 rst asserted 1 clk after the second rd_done -> all outputs 0, no time_valid;
//    the next poll starts again from 81h.
//  6 (TIMEOUT_EN, TIMEOUT_CYC=50) no rd_done for the minute read -> err=1 at WAIT
//    cycle 50, outputs keep the prior snapshot; next good poll clears err.

Source files
------------

// File: rtl/rtc_poll_sched_if.sv
// Read-engine bus between the poll scheduler (master) and the DS1302 read
// engine (slave): start strobe and command byte out, busy/done/data back.
interface rtc_poll_sched_if;
  logic       rd_start;
  logic [7:0] rd_cmd;
  logic       rd_busy;
  logic       rd_done;
  logic [7:0] rd_data;

  modport master (
    output rd_start,
    output rd_cmd,
    input  rd_busy,
    input  rd_done,
    input  rd_data
  );

  modport slave (
    input  rd_start,
    input  rd_cmd,
    output rd_busy,
    output rd_done,
    output rd_data
  );
endinterface

// File: rtl/rtc_poll_sched.sv
// rtc_poll_sched: periodic DS1302 time poller.
// Every POLL_TICKS tick pulses (or on force_poll) it reads seconds, minutes and
// hours through the read engine, stages them, and commits all three at once so
// downstream display logic only ever sees a coherent snapshot.
// Optional feature macro: RTC_SCHED_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts a stalled read after TIMEOUT_CYC clocks and raises a sticky err flag.
module rtc_poll_sched #(
  parameter int unsigned POLL_TICKS  = 100,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [7:0]  CMD_SEC     = 8'h81,
  parameter logic [7:0]  CMD_MIN     = 8'h83,
  parameter logic [7:0]  CMD_HOUR    = 8'h85
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   force_poll,
  rtc_poll_sched_if.master       rd,
  output logic [7:0]             sec_bcd,
  output logic [7:0]             min_bcd,
  output logic [7:0]             hour_bcd,
  output logic                   time_valid,
  output logic                   err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam int unsigned   PW        = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TICKS - 1);

  // CH (clock-halt) bit lives in bit 7 of seconds; hours keep only the
  // 24h/12h value bits, dropping the mode and AM/PM-adjacent upper bits.
  localparam logic [7:0] MASK_SEC  = 8'h7F;
  localparam logic [7:0] MASK_MIN  = 8'h7F;
  localparam logic [7:0] MASK_HOUR = 8'h3F;

  // Zero intervals would never fire or abort immediately; reject at elaboration.
  if (POLL_TICKS < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("rtc_poll_sched: POLL_TICKS and TIMEOUT_CYC must be >= 1");
  end

  state_t        state_r;
  logic [1:0]    idx_r;
  logic [PW-1:0] poll_cnt_r;
  logic          pend_r;
  logic          rd_start_r;
  logic [7:0]    rd_cmd_r;
  logic [7:0]    stage_sec_r;
  logic [7:0]    stage_min_r;
  logic [7:0]    stage_hour_r;
  logic [7:0]    sec_r;
  logic [7:0]    min_r;
  logic [7:0]    hour_r;
  logic          time_valid_r;
  logic          poll_hit_s;
  logic          req_s;

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int unsigned   TW           = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wait_cnt_r;
  logic          err_r;
`endif

  // Command byte for each step of the read sequence.
  function automatic logic [7:0] cmd_for(input logic [1:0] i);
    case (i)
      2'd0:    cmd_for = CMD_SEC;
      2'd1:    cmd_for = CMD_MIN;
      2'd2:    cmd_for = CMD_HOUR;
      default: cmd_for = CMD_SEC;
    endcase
  endfunction

  // Poll request decode: interval wrap from the tick timebase, or a forced poll.
  always_comb begin
    poll_hit_s = 1'b0;
    if (tick && (poll_cnt_r == POLL_LAST)) begin
      poll_hit_s = 1'b1;
    end else begin
      poll_hit_s = 1'b0;
    end
    req_s = poll_hit_s | force_poll;
  end

  // Poll timebase, pending-request latch and the read/commit sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= 2'd0;
      poll_cnt_r   <= '0;
      pend_r       <= 1'b0;
      rd_start_r   <= 1'b0;
      rd_cmd_r     <= 8'h00;
      stage_sec_r  <= 8'h00;
      stage_min_r  <= 8'h00;
      stage_hour_r <= 8'h00;
      sec_r        <= 8'h00;
      min_r        <= 8'h00;
      hour_r       <= 8'h00;
      time_valid_r <= 1'b0;
`ifdef RTC_SCHED_TIMEOUT_EN
      wait_cnt_r   <= '0;
      err_r        <= 1'b0;
`endif
    end else begin
      rd_start_r   <= 1'b0;
      time_valid_r <= 1'b0;

      if (tick) begin
        poll_cnt_r <= poll_hit_s ? '0 : poll_cnt_r + PW'(1);
      end

      // One-deep request latch; a request landing as IDLE consumes the
      // previous one is kept (set wins over clear below).
      if (req_s) begin
        pend_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          if (pend_r) begin
            pend_r  <= req_s;
            idx_r   <= 2'd0;
            state_r <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!rd.rd_busy) begin
            rd_start_r <= 1'b1;
            rd_cmd_r   <= cmd_for(idx_r);
`ifdef RTC_SCHED_TIMEOUT_EN
            wait_cnt_r <= '0;
`endif
            state_r    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (rd.rd_done) begin
            case (idx_r)
              2'd0: begin
                stage_sec_r <= rd.rd_data & MASK_SEC;
                idx_r       <= 2'd1;
                state_r     <= ST_ISSUE;
              end
              2'd1: begin
                stage_min_r <= rd.rd_data & MASK_MIN;
                idx_r       <= 2'd2;
                state_r     <= ST_ISSUE;
              end
              2'd2: begin
                stage_hour_r <= rd.rd_data & MASK_HOUR;
                state_r      <= ST_COMMIT;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
`ifdef RTC_SCHED_TIMEOUT_EN
          else if (wait_cnt_r == TIMEOUT_LAST) begin
            // Stalled engine: drop the partial sequence, keep old snapshot.
            err_r   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + TW'(1);
          end
`endif
        end

        ST_COMMIT: begin
          sec_r        <= stage_sec_r;
          min_r        <= stage_min_r;
          hour_r       <= stage_hour_r;
          time_valid_r <= 1'b1;
`ifdef RTC_SCHED_TIMEOUT_EN
          err_r        <= 1'b0;
`endif
          state_r      <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd.rd_start = rd_start_r;
  assign rd.rd_cmd   = rd_cmd_r;
  assign sec_bcd     = sec_r;
  assign min_bcd     = min_r;
  assign hour_bcd    = hour_r;
  assign time_valid  = time_valid_r;

`ifdef RTC_SCHED_TIMEOUT_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_poll_sched.sv
// Directed testbench for rtc_poll_sched with a small behavioural read engine.
module tb_rtc_poll_sched;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       tick       = 1'b0;
  logic       force_poll = 1'b0;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       time_valid;
  logic       err;

  rtc_poll_sched_if bus ();

  rtc_poll_sched #(
    .POLL_TICKS  (4),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .force_poll (force_poll),
    .rd         (bus),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .hour_bcd   (hour_bcd),
    .time_valid (time_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Cycle counter, advanced on each active edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural read engine: busy for 3 clocks after a strobe, then done+data.
  logic       eng_active = 1'b0;
  logic       eng_done   = 1'b0;
  logic [7:0] eng_data   = 8'h00;
  logic [7:0] eng_cmd    = 8'h00;
  int         eng_cnt    = 0;
  logic       force_busy = 1'b0;
  logic       eng_mute_min = 1'b0;
  logic [7:0] val_sec  = 8'h00;
  logic [7:0] val_min  = 8'h00;
  logic [7:0] val_hour = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      eng_active <= 1'b0;
      eng_done   <= 1'b0;
      eng_cnt    <= 0;
    end else begin
      eng_done <= 1'b0;
      if (!eng_active && bus.rd_start) begin
        eng_active <= 1'b1;
        eng_cnt    <= 3;
        eng_cmd    <= bus.rd_cmd;
      end else if (eng_active) begin
        if (eng_cnt == 1) begin
          eng_active <= 1'b0;
          if (!(eng_mute_min && eng_cmd == 8'h83)) begin
            eng_done <= 1'b1;
            eng_data <= (eng_cmd == 8'h81) ? val_sec :
                        (eng_cmd == 8'h83) ? val_min : val_hour;
          end
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  assign bus.rd_busy = eng_active | force_busy;
  assign bus.rd_done = eng_done;
  assign bus.rd_data = eng_data;

  // Monitor: strobe log, pulse counts, strobe width and output stability.
  logic [7:0] cmd_log[$];
  int         start_cyc_q[$];
  int         n_start = 0, n_done = 0, n_tv = 0;
  int         last_done_cyc = 0, last_tv_cyc = 0;
  int         wide_start = 0, unstable = 0;
  logic       prev_start = 1'b0;
  logic [23:0] prev_out = 24'h0;

  always @(negedge clk) begin
    if (bus.rd_start) begin
      n_start++;
      cmd_log.push_back(bus.rd_cmd);
      start_cyc_q.push_back(cyc);
      if (prev_start) wide_start++;
    end
    if (bus.rd_done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (time_valid) begin
      n_tv++;
      last_tv_cyc = cyc;
    end
    if (!rst && !time_valid && ({sec_bcd, min_bcd, hour_bcd} !== prev_out)) unstable++;
    prev_start = bus.rd_start;
    prev_out   = {sec_bcd, min_bcd, hour_bcd};
  end

  // Tick timebase: one pulse every 10 clocks while enabled.
  logic tick_en = 1'b0;
  int   tick_div = 0;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (tick_en) begin
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        tick     = (tick_div == 9);
      end else begin
        tick_div = 0;
        tick     = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic pulse_force();
    force_poll = 1'b1;
    step();
    force_poll = 1'b0;
  endtask

  task automatic wait_tv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (time_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests++; if (bus.rd_start !== 1'b0) begin fails++; $display("FAIL reset_rd_start got=%b exp=0", bus.rd_start); end
    tests++; if (bus.rd_cmd !== 8'h00) begin fails++; $display("FAIL reset_rd_cmd got=%h exp=00", bus.rd_cmd); end
    tests++; if (sec_bcd !== 8'h00) begin fails++; $display("FAIL reset_sec got=%h exp=00", sec_bcd); end
    tests++; if (min_bcd !== 8'h00) begin fails++; $display("FAIL reset_min got=%h exp=00", min_bcd); end
    tests++; if (hour_bcd !== 8'h00) begin fails++; $display("FAIL reset_hour got=%h exp=00", hour_bcd); end
    tests++; if (time_valid !== 1'b0) begin fails++; $display("FAIL reset_time_valid got=%b exp=0", time_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_poll();
    bit ok;
    val_sec = 8'h59; val_min = 8'h30; val_hour = 8'h12;
    cmd_log.delete();
    tick_en = 1'b1;
    wait_tv(300, ok);
    tick_en = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL basic_tv_timeout got=none exp=pulse"); end
    tests++; if (cmd_log.size() !== 3) begin fails++; $display("FAIL basic_cmd_count got=%0d exp=3", cmd_log.size()); end
    tests++; if (cmd_log[0] !== 8'h81) begin fails++; $display("FAIL basic_cmd0 got=%h exp=81", cmd_log[0]); end
    tests++; if (cmd_log[1] !== 8'h83) begin fails++; $display("FAIL basic_cmd1 got=%h exp=83", cmd_log[1]); end
    tests++; if (cmd_log[2] !== 8'h85) begin fails++; $display("FAIL basic_cmd2 got=%h exp=85", cmd_log[2]); end
    tests++; if (sec_bcd !== 8'h59) begin fails++; $display("FAIL basic_sec got=%h exp=59", sec_bcd); end
    tests++; if (min_bcd !== 8'h30) begin fails++; $display("FAIL basic_min got=%h exp=30", min_bcd); end
    tests++; if (hour_bcd !== 8'h12) begin fails++; $display("FAIL basic_hour got=%h exp=12", hour_bcd); end
    // Done visible in cycle j is consumed at edge j+1; time_valid shows at edge j+2.
    tests++; if (last_tv_cyc - last_done_cyc !== 2) begin fails++; $display("FAIL basic_tv_latency got=%0d exp=2", last_tv_cyc - last_done_cyc); end
    repeat (3) step();
  endtask

  task automatic test_mask();
    bit ok;
    int f_cyc;
    val_sec = 8'hD9; val_min = 8'hB0; val_hour = 8'hD2;
    cmd_log.delete();
    start_cyc_q.delete();
    f_cyc = cyc;
    pulse_force();
    wait_tv(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mask_tv_timeout got=none exp=pulse"); end
    tests++; if (sec_bcd !== 8'h59) begin fails++; $display("FAIL mask_sec got=%h exp=59", sec_bcd); end
    tests++; if (min_bcd !== 8'h30) begin fails++; $display("FAIL mask_min got=%h exp=30", min_bcd); end
    tests++; if (hour_bcd !== 8'h12) begin fails++; $display("FAIL mask_hour got=%h exp=12", hour_bcd); end
    // force_poll -> pend (edge 1) -> IDLE sees pend (edge 2) -> rd_start (edge 3).
    tests++; if (start_cyc_q[0] - f_cyc !== 3) begin fails++; $display("FAIL mask_start_latency got=%0d exp=3", start_cyc_q[0] - f_cyc); end
    repeat (3) step();
  endtask

  task automatic test_force_merge();
    int base_start, base_tv;
    bit ok;
    val_sec = 8'h11; val_min = 8'h22; val_hour = 8'h03;
    cmd_log.delete();
    base_start = n_start;
    base_tv    = n_tv;
    pulse_force();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (n_start == base_start + 2) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL merge_reach_wait1 got=%0d exp=%0d", n_start - base_start, 2); end
    pulse_force();
    step();
    pulse_force();
    repeat (150) step();
    tests++; if (n_tv - base_tv !== 2) begin fails++; $display("FAIL merge_tv_count got=%0d exp=2", n_tv - base_tv); end
    tests++; if (cmd_log.size() !== 6) begin fails++; $display("FAIL merge_cmd_count got=%0d exp=6", cmd_log.size()); end
    tests++; if (cmd_log[3] !== 8'h81) begin fails++; $display("FAIL merge_restart_cmd got=%h exp=81", cmd_log[3]); end
    tests++; if (cmd_log[5] !== 8'h85) begin fails++; $display("FAIL merge_last_cmd got=%h exp=85", cmd_log[5]); end
    tests++; if (hour_bcd !== 8'h03) begin fails++; $display("FAIL merge_hour got=%h exp=03", hour_bcd); end
  endtask

  task automatic test_busy_hold();
    int base_start;
    bit ok;
    val_sec = 8'h07; val_min = 8'h08; val_hour = 8'h09;
    base_start = n_start;
    force_busy = 1'b1;
    pulse_force();
    repeat (20) step();
    tests++; if (n_start !== base_start) begin fails++; $display("FAIL busy_no_strobe got=%0d exp=0", n_start - base_start); end
    force_busy = 1'b0;
    wait_tv(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL busy_tv_timeout got=none exp=pulse"); end
    tests++; if (n_start - base_start !== 3) begin fails++; $display("FAIL busy_strobe_count got=%0d exp=3", n_start - base_start); end
    tests++; if (wide_start !== 0) begin fails++; $display("FAIL busy_strobe_width got=%0d exp=0", wide_start); end
    tests++; if (sec_bcd !== 8'h07) begin fails++; $display("FAIL busy_sec got=%h exp=07", sec_bcd); end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int base_done, base_start, base_tv;
    bit ok;
    val_sec = 8'h45; val_min = 8'h15; val_hour = 8'h08;
    base_done = n_done;
    pulse_force();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (n_done == base_done + 2) begin ok = 1'b1; break; end
      step();
    end
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_second_done got=%0d exp=2", n_done - base_done); end
    step();
    rst = 1'b1;
    base_start = n_start;
    base_tv    = n_tv;
    repeat (2) step();
    tests++; if (sec_bcd !== 8'h00) begin fails++; $display("FAIL rstmid_sec got=%h exp=00", sec_bcd); end
    tests++; if (min_bcd !== 8'h00) begin fails++; $display("FAIL rstmid_min got=%h exp=00", min_bcd); end
    tests++; if (hour_bcd !== 8'h00) begin fails++; $display("FAIL rstmid_hour got=%h exp=00", hour_bcd); end
    tests++; if (bus.rd_cmd !== 8'h00) begin fails++; $display("FAIL rstmid_rd_cmd got=%h exp=00", bus.rd_cmd); end
    rst = 1'b0;
    repeat (30) step();
    tests++; if (n_tv !== base_tv) begin fails++; $display("FAIL rstmid_no_tv got=%0d exp=0", n_tv - base_tv); end
    tests++; if (n_start !== base_start) begin fails++; $display("FAIL rstmid_no_strobe got=%0d exp=0", n_start - base_start); end
    cmd_log.delete();
    pulse_force();
    wait_tv(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rstmid_tv_timeout got=none exp=pulse"); end
    tests++; if (cmd_log[0] !== 8'h81) begin fails++; $display("FAIL rstmid_restart_cmd got=%h exp=81", cmd_log[0]); end
    tests++; if (sec_bcd !== 8'h45) begin fails++; $display("FAIL rstmid_sec2 got=%h exp=45", sec_bcd); end
    tests++; if (hour_bcd !== 8'h08) begin fails++; $display("FAIL rstmid_hour2 got=%h exp=08", hour_bcd); end
    repeat (3) step();
  endtask

`ifdef RTC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int base_tv, err_cyc;
    bit ok;
    eng_mute_min = 1'b1;
    val_sec = 8'h21;
    base_tv = n_tv;
    start_cyc_q.delete();
    pulse_force();
    ok = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (err) begin ok = 1'b1; err_cyc = cyc; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL timeout_err_rise got=0 exp=1"); end
    // WAIT entered with the 83h strobe; abort at the 50th WAIT cycle.
    tests++; if (err_cyc - start_cyc_q[1] !== 50) begin fails++; $display("FAIL timeout_latency got=%0d exp=50", err_cyc - start_cyc_q[1]); end
    tests++; if (sec_bcd !== 8'h45) begin fails++; $display("FAIL timeout_keep_sec got=%h exp=45", sec_bcd); end
    tests++; if (min_bcd !== 8'h15) begin fails++; $display("FAIL timeout_keep_min got=%h exp=15", min_bcd); end
    tests++; if (n_tv !== base_tv) begin fails++; $display("FAIL timeout_no_tv got=%0d exp=0", n_tv - base_tv); end
    eng_mute_min = 1'b0;
    val_sec = 8'h33; val_min = 8'h44; val_hour = 8'h05;
    repeat (5) step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", err); end
    pulse_force();
    wait_tv(100, ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout_recover_tv got=none exp=pulse"); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear got=%b exp=0", err); end
    tests++; if (sec_bcd !== 8'h33) begin fails++; $display("FAIL timeout_recover_sec got=%h exp=33", sec_bcd); end
  endtask
`else
  task automatic test_err_tied();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_tied got=%b exp=0", err); end
  endtask
`endif

  task automatic test_stability();
    tests++; if (unstable !== 0) begin fails++; $display("FAIL output_stability got=%0d exp=0", unstable); end
    tests++; if (wide_start !== 0) begin fails++; $display("FAIL strobe_width got=%0d exp=0", wide_start); end
  endtask

  initial begin
    test_reset();
    test_basic_poll();
    test_mask();
    test_force_merge();
    test_busy_hold();
    test_reset_mid();
`ifdef RTC_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    test_stability();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
